// File: rtl/mac_pipe_if.sv
// Host-side bus of the multiply-accumulate engine: register-file write port,
// operation issue port and the result stream.
interface mac_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              w_en_n;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              in_valid;
  logic              in_mode;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] b_data;
  logic              out_valid;
  logic [DATA_W-1:0] result;

  modport master (
    output w_en_n, w_addr, w_data, in_valid, in_mode, a_addr, b_data,
    input  out_valid, result
  );

  modport slave (
    input  w_en_n, w_addr, w_data, in_valid, in_mode, a_addr, b_data,
    output out_valid, result
  );
endinterface

// File: rtl/mac_pipe.sv
// Register file with async operand read feeding a PIPE-deep multiplier whose
// result register doubles as the accumulator (MUL re-seeds, MAC adds).
module mac_pipe #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int PIPE   = 2
) (
  input  logic     clock,
  input  logic     reset_n,
  mac_pipe_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return full[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] acc_wrap(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] p);
    return acc + p;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_hit;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] opa_p [PIPE];
  logic [DATA_W-1:0] opb_p [PIPE];
  logic [PIPE-1:0]   mode_p;
  logic [PIPE-1:0]   vld_p;

  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] result_q;
  logic              out_vld_q;

  assign wr_hit  = !bus.w_en_n && ({1'b0, bus.w_addr} < DEPTH_C);
  assign rd_hit  = {1'b0, bus.a_addr} < DEPTH_C;
  assign rd_data = rd_hit ? mem[bus.a_addr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[bus.w_addr] <= bus.w_data;
    end
  end

  // Operand stages: stage 0 samples the old memory word, the rest just shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p  <= '0;
      mode_p <= '0;
      for (int k = 0; k < PIPE; k++) begin
        opa_p[k] <= '0;
        opb_p[k] <= '0;
      end
    end else begin
      vld_p[0]  <= bus.in_valid;
      mode_p[0] <= bus.in_mode;
      opa_p[0]  <= rd_data;
      opb_p[0]  <= bus.b_data;
      for (int k = 1; k < PIPE; k++) begin
        vld_p[k]  <= vld_p[k-1];
        mode_p[k] <= mode_p[k-1];
        opa_p[k]  <= opa_p[k-1];
        opb_p[k]  <= opb_p[k-1];
      end
    end
  end

  assign prod = mul_trunc(opa_p[PIPE-1], opb_p[PIPE-1]);

  // Result stage: holds across bubbles so consecutive MACs chain without gaps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= vld_p[PIPE-1];
      if (vld_p[PIPE-1]) begin
        result_q <= mode_p[PIPE-1] ? acc_wrap(result_q, prod) : prod;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_vld_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: hand-derived expected results are queued at
// issue time and matched against the output stream on every clock edge.
module tb_mac_pipe;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 200;
  localparam int ADDR_W = 8;
  localparam int PIPE   = 2;

  typedef struct {
    int               due;
    logic [DATA_W-1:0] val;
  } sb_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;
  logic [DATA_W-1:0] hold;
  sb_t  sb[$];

  mac_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mac_pipe #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .PIPE  (PIPE)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge, then compare outputs against the scoreboard head.
  task automatic step();
    sb_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("out_valid_pulse", {31'd0, bus.out_valid}, 32'd1);
      check("result", {16'd0, bus.result}, {16'd0, e.val});
      hold = e.val;
    end else begin
      check("out_valid_idle", {31'd0, bus.out_valid}, 32'd0);
      check("result_hold", {16'd0, bus.result}, {16'd0, hold});
    end
    bus.in_valid = 1'b0;
    bus.w_en_n   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.w_en_n = 1'b0;
    bus.w_addr = addr;
    bus.w_data = data;
    step();
  endtask

  task automatic issue(input logic mode, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp);
    sb_t e;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.a_addr   = addr;
    bus.b_data   = b;
    e.due = cyc + 1 + PIPE;
    e.val = exp;
    sb.push_back(e);
    step();
  endtask

  task automatic issue_wr(input logic mode, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp,
                          input logic [DATA_W-1:0] wdata);
    bus.w_en_n = 1'b0;
    bus.w_addr = addr;
    bus.w_data = wdata;
    issue(mode, addr, b, exp);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    hold         = '0;
    reset_n      = 1'b0;
    bus.w_en_n   = 1'b1;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'b0;
    bus.a_addr   = '0;
    bus.b_data   = '0;

    // Reset state
    idle(3);
    #2 reset_n = 1'b1;
    idle(1);
    issue(1'b0, 8'd7,   16'h0001, 16'h0000);
    issue(1'b0, 8'd199, 16'h0005, 16'h0000);
    idle(3);

    // MUL latency: 3 * 7 = 0x15
    wr(8'd5, 16'h0003);
    issue(1'b0, 8'd5, 16'h0007, 16'h0015);
    idle(3);

    // MAC chain with wrap
    wr(8'd1, 16'h8000);
    issue(1'b0, 8'd1, 16'h0001, 16'h8000);
    issue(1'b1, 8'd1, 16'h0001, 16'h0000);
    issue(1'b1, 8'd1, 16'h0003, 16'h8000);
    idle(3);

    // Product truncation: 0xFFFF * 0xFFFF = 0xFFFE0001
    wr(8'd2, 16'hFFFF);
    issue(1'b0, 8'd2, 16'hFFFF, 16'h0001);
    idle(3);

    // Same-address hazard plus a bubble
    wr(8'd9, 16'd2);
    issue(1'b0, 8'd9, 16'h0001, 16'd2);
    issue_wr(1'b1, 8'd9, 16'h0001, 16'd4, 16'd100);
    idle(1);
    issue(1'b1, 8'd9, 16'h0001, 16'd104);
    idle(4);

    // Out-of-range write/read and the last in-range entry
    wr(8'd250, 16'h1234);
    issue(1'b0, 8'd250, 16'h0005, 16'h0000);
    wr(8'd199, 16'h0007);
    issue(1'b0, 8'd199, 16'h0002, 16'h000E);
    idle(3);

    // Reset mid-operation
    issue(1'b0, 8'd5, 16'h0007, 16'h0015);
    issue(1'b1, 8'd1, 16'h0001, 16'h8015);
    reset_n = 1'b0;
    sb.delete();
    hold = '0;
    #2;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_result", {16'd0, bus.result}, 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(3);
    issue(1'b0, 8'd5, 16'h0007, 16'h0000);
    issue(1'b0, 8'd2, 16'hFFFF, 16'h0000);
    issue(1'b0, 8'd1, 16'h0001, 16'h0000);
    idle(4);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised multiply-accumulate engine: a register file with one synchronous write port and one asynchronous operand read port, feeding a PIPE-deep registered multiplier with valid tracking and an accumulate mode. It is the next generation of the fixed 16-bit regfile+multiplier datapath. It sits between the host write interface and downstream consumers of `result`.

## Interface
- `DATA_W`, 16: operand, memory word and result width.
- `DEPTH`, 256: register-file entries; need not be a power of two.
- `ADDR_W`, 8: address width; must satisfy 2^ADDR_W >= DEPTH.
- `PIPE`, 2: operand pipeline stages before the result register; legal range 1..8.
- `clock` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `w_en_n` input 1: active-low register-file write enable.
- `w_addr` input ADDR_W: write address.
- `w_data` input DATA_W: write data.
- `in_valid` input 1: issue one operation this cycle.
- `in_mode` input 1: 0 = MUL, 1 = MAC.
- `a_addr` input ADDR_W: register-file address of operand A.
- `b_data` input DATA_W: operand B.
- `out_valid` output 1: `result` holds a new value this cycle (one-cycle pulse per operation).
- `result` output DATA_W: operation result / accumulator value.

## Operation
- Register file is DEPTH x DATA_W.
  - Write occurs on a clock edge when `w_en_n`=0 and `w_addr` < DEPTH.
  - Writes with `w_addr` >= DEPTH are dropped.
- Read is combinational: `mem[a_addr]`, or 0 if `a_addr` >= DEPTH.
- Read/write to the same address in the same cycle: the read returns the old contents. There is no bypass; the new value is visible from the next cycle.
- Issue: on an edge with `in_valid`=1, stage 0 captures {A = `mem[a_addr]`, B = `b_data`, mode, valid=1}.
- On an edge with `in_valid`=0, stage 0 captures valid=0. Data contents are don't-care.
- Stages 1..PIPE-1 shift unconditionally every cycle. There is no backpressure and no stall.
- Result stage, from the last operand stage:
  - Product P = low DATA_W bits of A*B (unsigned; upper bits discarded).
  - If valid and mode=MUL: `result` <= P.
  - If valid and mode=MAC: `result` <= (`result` + P) mod 2^DATA_W.
  - If not valid: `result` holds; `out_valid` <= 0.
  - If valid: `out_valid` <= 1.
- `result` is the accumulator: a MUL both outputs P and re-seeds the accumulation.
- Back-to-back MACs accumulate with no bubble; each consecutive valid op sees the previous op's result.

## Timing
- Reset (asynchronous assert, any time): all memory entries, all stage valids and data, `result`, and `out_valid` go to 0 immediately.
  - Operations in flight are discarded and never produce `out_valid`.
- Reset release: the first issue is accepted on the first rising edge with `reset_n`=1.
- Latency: op issued at edge N produces `out_valid`=1 and its `result` after edge N+PIPE, i.e. PIPE+1 edges including the issue edge. With PIPE=2, issue at edge 0 gives output at edge 2, matching the three-register depth of the previous generation.
- Throughput: one operation per cycle.
- A write at edge N is visible to an issue at edge N+1 or later.
- A write landing after issue does not affect that in-flight operation.
- Simultaneous write and issue at the same address and edge: the op uses the old value.

## Test plan
- Reset state: hold `reset_n`=0, then release → `result`=0, `out_valid`=0. A read of any address in range returns 0.
- MUL latency (PIPE=2, DATA_W=16):
  - Write mem[5]=0x0003, then issue MUL with a_addr=5, b=0x0007 at edge N.
  - Expect `out_valid` pulse and `result`=0x0015 after edge N+2, with `out_valid`=0 on neighbouring cycles.
- MAC chain and wrap:
  - Write mem[1]=0x8000.
  - Issue back-to-back: MUL(1, b=1), MAC(1, b=1), MAC(1, b=3).
  - Expect results 0x8000, 0x0000 (wrap), 0x8000 on three consecutive cycles.
- Product truncation: mem[2]=0xFFFF, MUL b=0xFFFF → `result`=0x0001.
- Bubble and same-address hazard:
  - mem[9]=2. Issue MAC(9, b=1) while writing mem[9]=100 on the same edge.
  - Idle one cycle, then issue MAC(9, b=1).
  - Expect the first MAC to add 2 and the second to add 100. `result` holds during the bubble, with no `out_valid` in that cycle.
- Reset mid-operation: issue 2 ops, assert `reset_n` before their output edge → no `out_valid` pulse, `result`=0, memory cleared.
- Out-of-range (DEPTH=200): a write to address 250 is dropped; a read of address 250 returns 0, so MUL yields 0.
